// File: rtl/fp_mult_result_collector_pkg.sv
//============================================================================
// Module   : fp_mult_pkg
// Brief    : Shared types and status-bit indices for the FP multiplier
//            result collector.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package fp_mult_pkg;

    localparam int STATUS_W   = 8;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    typedef struct packed {
        logic [31:0]         z;
        logic [STATUS_W-1:0] st;
    } fp_res_t;

endpackage

`default_nettype wire

// File: rtl/fp_mult_result_collector_if.sv
//============================================================================
// Module   : fp_mult_result_collector_if
// Brief    : Operand-issue and result-stream signals of the collector.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface fp_mult_result_collector_if;
    import fp_mult_pkg::*;

    logic                op_valid;
    logic                op_ready;
    logic [31:0]         z;
    logic [STATUS_W-1:0] status;
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         res_z;
    logic [STATUS_W-1:0] res_status;

    // master: upstream issuer / multiplier / result consumer side
    modport master (
        output op_valid, z, status, res_ready,
        input  op_ready, res_valid, res_z, res_status
    );

    modport slave (
        input  op_valid, z, status, res_ready,
        output op_ready, res_valid, res_z, res_status
    );

endinterface

`default_nettype wire

// File: rtl/fp_mult_result_collector_fifo.sv
//============================================================================
// Module   : fp_res_fifo
// Brief    : First-word-fall-through result FIFO with occupancy output.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module fp_res_fifo
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_push,
    input  wire fp_res_t               i_din,
    input  wire logic                  i_pop,
    output fp_res_t                    o_dout,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    fp_res_t       r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    // A push into a full FIFO is legal only when the head leaves this cycle
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
    end

endmodule

`default_nettype wire

// File: rtl/fp_mult_result_collector.sv
//============================================================================
// Module   : fp_mult_result_collector
// Brief    : Tags multiplier issues, buffers aligned results, issues
//            credit-based op_ready, accumulates sticky flags and drops.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module fp_mult_result_collector
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LAT   = 2,
    parameter int CNT_W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    fp_mult_result_collector_if.slave  bus,
    input  wire logic                  sticky_clr,
    output logic [STATUS_W-1:0]        sticky_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int c_SUM_W = $clog2(DEPTH + LAT + 1) + 1;

    logic [LAT-1:0]      r_tag;
    logic [STATUS_W-1:0] r_sticky;
    logic [CNT_W-1:0]    r_drop;
    logic [c_SUM_W-1:0]  w_inflight;
    logic [c_SUM_W-1:0]  w_committed;
    logic                w_arrival;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    fp_res_t             w_din;
    fp_res_t             w_dout;

    generate
        if (LAT == 1) begin : g_tag_lat1
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_tag <= '0;
                else      r_tag <= bus.op_valid;
            end
        end else begin : g_tag_latn
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_tag <= '0;
                else      r_tag <= {r_tag[LAT-2:0], bus.op_valid};
            end
        end
    endgenerate

    assign w_arrival = r_tag[LAT-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_tag[i]);
        end
    end

    // Same-cycle pops are deliberately not credited back
    assign w_committed  = c_SUM_W'(level) + w_inflight;
    assign bus.op_ready = (w_committed < c_SUM_W'(DEPTH));

    assign w_pop         = bus.res_valid && bus.res_ready;
    assign w_push        = w_arrival && (!w_full || w_pop);
    assign w_drop        = w_arrival && w_full && !w_pop;
    assign w_din.z       = bus.z;
    assign w_din.st      = bus.status;
    assign bus.res_valid = !w_empty;
    assign bus.res_z     = w_dout.z;
    assign bus.res_status = w_dout.st;

    fp_res_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A clear coinciding with an arrival keeps the new event's flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sticky <= '0;
            r_drop   <= '0;
        end else begin
            if (w_arrival) begin
                r_sticky <= sticky_clr ? bus.status : (r_sticky | bus.status);
            end else if (sticky_clr) begin
                r_sticky <= '0;
            end
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
        end
    end

    assign sticky_flags = r_sticky;
    assign drop_cnt     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_result_collector.sv
//============================================================================
// Module   : tb_fp_mult_result_collector
// Brief    : Randomised self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fp_mult_result_collector;
    import fp_mult_pkg::*;

    localparam int DEPTH   = 8;
    localparam int LAT     = 2;
    localparam int CNT_W   = 8;
    localparam int c_SATV  = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sticky_clr;
    logic [STATUS_W-1:0]     sticky_flags;
    logic [$clog2(DEPTH):0]  level;
    logic [CNT_W-1:0]        drop_cnt;

    always #5 clk = ~clk;

    fp_mult_result_collector_if bus ();

    fp_mult_result_collector #(
        .DEPTH        (DEPTH),
        .LAT          (LAT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .level        (level),
        .drop_cnt     (drop_cnt)
    );

    // Stand-in multiplier: whatever result is scheduled with an issue appears LAT cycles later
    logic [31:0] op_z;
    logic [7:0]  op_st;
    logic [31:0] mz [LAT];
    logic [7:0]  ms [LAT];

    always @(posedge clk) begin
        mz[0] <= op_z;
        ms[0] <= op_st;
        for (int i = 1; i < LAT; i++) begin
            mz[i] <= mz[i-1];
            ms[i] <= ms[i-1];
        end
    end

    assign bus.z      = mz[LAT-1];
    assign bus.status = ms[LAT-1];

    typedef struct {
        int          t;
        logic [31:0] z;
        logic [7:0]  st;
    } op_t;

    op_t        pend[$];
    fp_res_t    q[$];
    int         m_drop;
    logic [7:0] m_sticky;
    int         cyc;
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_ready();
        return (q.size() + pend.size()) < DEPTH;
    endfunction

    task automatic model_clear();
        pend.delete();
        q.delete();
        m_drop   = 0;
        m_sticky = '0;
    endtask

    task automatic check_all();
        logic [31:0] ez;
        logic [7:0]  es;
        ez = '0;
        es = '0;
        if (q.size() != 0) begin
            ez = q[0].z;
            es = q[0].st;
        end
        check("res_valid",  32'(bus.res_valid),  32'(q.size() != 0));
        check("res_z",      bus.res_z,           ez);
        check("res_status", 32'(bus.res_status), 32'(es));
        check("level",      32'(level),          32'(q.size()));
        check("drop_cnt",   32'(drop_cnt),       32'(m_drop));
        check("sticky",     32'(sticky_flags),   32'(m_sticky));
        check("op_ready",   32'(bus.op_ready),   32'(m_ready()));
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic cycle(input bit ov, input logic [31:0] oz, input logic [7:0] ost,
                         input bit rr, input bit clr);
        bit      pop;
        bit      arr;
        op_t     o;
        fp_res_t r;
        bus.op_valid  = ov;
        op_z          = oz;
        op_st         = ost;
        bus.res_ready = rr;
        sticky_clr    = clr;
        #1;
        check_all();
        pop = (q.size() > 0) && rr;
        arr = (pend.size() > 0) && (pend[0].t == cyc);
        if (pop) void'(q.pop_front());
        if (arr) begin
            o        = pend.pop_front();
            m_sticky = clr ? o.st : (m_sticky | o.st);
            if (q.size() < DEPTH) begin
                r.z  = o.z;
                r.st = o.st;
                q.push_back(r);
            end else if (m_drop < c_SATV) begin
                m_drop++;
            end
        end else if (clr) begin
            m_sticky = '0;
        end
        if (ov) pend.push_back('{t: cyc + LAT, z: oz, st: ost});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rr);
        repeat (n) cycle(1'b0, 32'h0, 8'h00, rr, 1'b0);
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.op_valid  = 1'b1;
        bus.res_ready = 1'b0;
        sticky_clr    = 1'b0;
        op_z          = '0;
        op_st         = '0;
        repeat (3) @(negedge clk);
        model_clear();
        #1;
        check_all();
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_cycles(input int n);
        bit ov;
        repeat (n) begin
            ov = ($urandom_range(0, 9) == 0) ? 1'b1 : (m_ready() && ($urandom_range(0, 1) == 1));
            cycle(ov, $urandom, 8'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        int acc;
        bit r;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b0;
        model_clear();

        // Reset held with op_valid asserted
        do_reset();
        check("rst_level", 32'(level), 32'd0);
        idle(4, 1'b1);

        // Latency: 2.0 * 3.0
        cycle(1'b1, 32'h40C0_0000, 8'h00, 1'b0, 1'b0);
        idle(LAT - 1, 1'b0);
        check("lat_early", 32'(bus.res_valid), 32'd0);
        idle(1, 1'b0);
        check("lat_valid", 32'(bus.res_valid), 32'd1);
        check("lat_z", bus.res_z, 32'h40C0_0000);
        idle(2, 1'b1);

        // Credit-limited streaming under backpressure
        do_reset();
        acc = 0;
        repeat (20) begin
            r = m_ready();
            if (r) acc++;
            cycle(r, $urandom, 8'h00, 1'b0, 1'b0);
        end
        check("bp_accepted", 32'(acc), 32'd8);
        check("bp_level", 32'(level), 32'd8);
        check("bp_op_ready", 32'(bus.op_ready), 32'd0);
        check("bp_drop", 32'(drop_cnt), 32'd0);
        idle(12, 1'b1);

        // Forced overflow and drop-counter saturation
        do_reset();
        repeat (10) cycle(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
        idle(LAT + 2, 1'b0);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_drop", 32'(drop_cnt), 32'd2);
        repeat (260) cycle(1'b1, $urandom, 8'h00, 1'b0, 1'b0);
        idle(LAT + 2, 1'b0);
        check("sat_drop", 32'(drop_cnt), 32'(c_SATV));

        // Sticky accumulation and clear-with-arrival
        do_reset();
        cycle(1'b1, 32'h1, 8'h04, 1'b1, 1'b0);
        cycle(1'b1, 32'h2, 8'h20, 1'b1, 1'b0);
        idle(4, 1'b1);
        check("sticky_or", 32'(sticky_flags), 32'h24);
        cycle(1'b1, 32'h3, 8'h01, 1'b1, 1'b0);
        idle(LAT - 1, 1'b1);
        cycle(1'b0, 32'h0, 8'h00, 1'b1, 1'b1);
        idle(1, 1'b1);
        check("sticky_clr_arr", 32'(sticky_flags), 32'h01);
        cycle(1'b0, 32'h0, 8'h00, 1'b1, 1'b1);
        check("sticky_clr", 32'(sticky_flags), 32'h00);

        // Push and pop together while full
        do_reset();
        repeat (12) cycle(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
        repeat (20) cycle(1'b1, $urandom, 8'($urandom), 1'b1, 1'b0);
        check("pp_level", 32'(level), 32'd8);
        idle(12, 1'b1);

        // Random traffic
        do_reset();
        rand_cycles(600);

        // Asynchronous reset mid-stream
        repeat (6) cycle(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
        bus.op_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(bus.res_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_op_ready", 32'(bus.op_ready), 32'd1);
        check("arst_sticky", 32'(sticky_flags), 32'd0);
        check("arst_res_z", bus.res_z, 32'd0);
        model_clear();
        @(negedge clk);
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        rand_cycles(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
